// File: rtl/seq_mult_fx_if.sv
// Handshake and operand/result bundle for the sequential fixed-point multiplier.
interface seq_mult_fx_if #(
  parameter int unsigned WIDTH = 18
);
  logic                 start;
  logic [WIDTH-1:0]     dataa;
  logic [WIDTH-1:0]     datab;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   result;
  logic [WIDTH-1:0]     result_fx;
  logic                 sat;

  modport master (
    output start, dataa, datab,
    input  busy, done, result, result_fx, sat
  );

  modport slave (
    input  start, dataa, datab,
    output busy, done, result, result_fx, sat
  );
endinterface

// File: rtl/seq_mult_fx.sv
// Radix-2 shift-add multiplier: one partial product per clock, full product plus
// a rescaled, saturated W-bit result for feeding a chaos-map iteration.
module seq_mult_fx #(
  parameter int unsigned WIDTH  = 18,
  parameter bit          SIGNED = 1'b1,
  parameter int unsigned FRAC   = 0
) (
  input logic          CLK,
  input logic          RST,
  seq_mult_fx_if.slave io_bus
);
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StCalc, StFin} state_e;

  state_e               r_state, w_state_next;
  logic [WIDTH-1:0]     r_ma, r_mb;
  logic                 r_neg;
  logic [2*WIDTH-1:0]   r_acc;
  logic [CW-1:0]        r_count;
  logic                 r_done;
  logic [2*WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]     r_result_fx;
  logic                 r_sat;

  logic [WIDTH-1:0]     w_abs_a, w_abs_b;
  logic                 w_neg_in;
  logic [2*WIDTH-1:0]   w_pp, w_prod, w_shift;
  logic [WIDTH-1:0]     w_fx;
  logic                 w_sat;

  // Magnitudes stay W-bit unsigned, so |-2^(W-1)| still fits.
  always_comb begin
    w_abs_a  = io_bus.dataa;
    w_abs_b  = io_bus.datab;
    w_neg_in = 1'b0;
    if (SIGNED) begin
      if (io_bus.dataa[WIDTH-1]) w_abs_a = -io_bus.dataa;
      if (io_bus.datab[WIDTH-1]) w_abs_b = -io_bus.datab;
      w_neg_in = io_bus.dataa[WIDTH-1] ^ io_bus.datab[WIDTH-1];
    end
  end

  assign w_pp   = r_mb[r_count] ? ({{WIDTH{1'b0}}, r_ma} << r_count) : '0;
  assign w_prod = r_neg ? -r_acc : r_acc;

  always_comb begin
    w_fx  = '0;
    w_sat = 1'b0;
    if (SIGNED) begin
      w_shift = $signed(w_prod) >>> FRAC;
      // In range only when every bit from the W-bit sign bit upward agrees.
      if (!(&w_shift[2*WIDTH-1:WIDTH-1]) && (|w_shift[2*WIDTH-1:WIDTH-1])) begin
        w_sat = 1'b1;
        w_fx  = w_shift[2*WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end else begin
        w_fx = w_shift[WIDTH-1:0];
      end
    end else begin
      w_shift = w_prod >> FRAC;
      if (|w_shift[2*WIDTH-1:WIDTH]) begin
        w_sat = 1'b1;
        w_fx  = '1;
      end else begin
        w_fx = w_shift[WIDTH-1:0];
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (io_bus.start) w_state_next = StCalc;
      StCalc:  if (r_count == CW'(WIDTH - 1)) w_state_next = StFin;
      StFin:   w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_ma        <= '0;
      r_mb        <= '0;
      r_neg       <= 1'b0;
      r_acc       <= '0;
      r_count     <= '0;
      r_done      <= 1'b0;
      r_result    <= '0;
      r_result_fx <= '0;
      r_sat       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (io_bus.start) begin
            r_ma    <= w_abs_a;
            r_mb    <= w_abs_b;
            r_neg   <= w_neg_in;
            r_acc   <= '0;
            r_count <= '0;
          end
        end
        StCalc: begin
          r_acc   <= r_acc + w_pp;
          r_count <= r_count + CW'(1);
        end
        StFin: begin
          r_result    <= w_prod;
          r_result_fx <= w_fx;
          r_sat       <= w_sat;
          r_done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign io_bus.busy      = (r_state != StIdle);
  assign io_bus.done      = r_done;
  assign io_bus.result    = r_result;
  assign io_bus.result_fx = r_result_fx;
  assign io_bus.sat       = r_sat;
endmodule

// File: tb/tb_seq_mult_fx.sv
// Bench for seq_mult_fx: five configurations share one stimulus stream; each has
// its own expected-result queue filled at start and drained on done.
module tb_seq_mult_fx;
  logic        CLK = 1'b0;
  logic        RST;
  logic        start;
  logic [17:0] a, b;

  always #5 CLK = ~CLK;

  seq_mult_fx_if #(.WIDTH(18)) if0 ();
  seq_mult_fx_if #(.WIDTH(18)) if1 ();
  seq_mult_fx_if #(.WIDTH(18)) if2 ();
  seq_mult_fx_if #(.WIDTH(8))  if3 ();
  seq_mult_fx_if #(.WIDTH(8))  if4 ();

  assign if0.start = start;  assign if0.dataa = a;       assign if0.datab = b;
  assign if1.start = start;  assign if1.dataa = a;       assign if1.datab = b;
  assign if2.start = start;  assign if2.dataa = a;       assign if2.datab = b;
  assign if3.start = start;  assign if3.dataa = a[7:0];  assign if3.datab = b[7:0];
  assign if4.start = start;  assign if4.dataa = a[7:0];  assign if4.datab = b[7:0];

  seq_mult_fx #(.WIDTH(18), .SIGNED(1'b0), .FRAC(0))  u0 (.CLK(CLK), .RST(RST), .io_bus(if0));
  seq_mult_fx #(.WIDTH(18), .SIGNED(1'b1), .FRAC(0))  u1 (.CLK(CLK), .RST(RST), .io_bus(if1));
  seq_mult_fx #(.WIDTH(18), .SIGNED(1'b1), .FRAC(16)) u2 (.CLK(CLK), .RST(RST), .io_bus(if2));
  seq_mult_fx #(.WIDTH(8),  .SIGNED(1'b0), .FRAC(0))  u3 (.CLK(CLK), .RST(RST), .io_bus(if3));
  seq_mult_fx #(.WIDTH(8),  .SIGNED(1'b1), .FRAC(4))  u4 (.CLK(CLK), .RST(RST), .io_bus(if4));

  typedef struct packed {
    logic [35:0] res;
    logic [17:0] fx;
    logic        sat;
  } exp_t;

  typedef struct {
    int          sel;
    logic [17:0] a;
    logic [17:0] b;
    logic [35:0] res;
    logic [17:0] fx;
    logic        sat;
  } vec_t;

  int unsigned cw [5] = '{18, 18, 18, 8, 8};
  int unsigned cs [5] = '{0, 1, 1, 0, 1};
  int unsigned cf [5] = '{0, 0, 16, 0, 4};

  exp_t sb [5][$];
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic exp_t model(input logic [17:0] ta, input logic [17:0] tb_,
                                 input int unsigned w, input int unsigned s,
                                 input int unsigned f);
    exp_t   e;
    longint m, ai, bi, p, sh, lo, hi, c;
    m  = (longint'(1) << w) - 1;
    ai = longint'(ta) & m;
    bi = longint'(tb_) & m;
    if (s != 0) begin
      if (((ai >> (w - 1)) & 1) != 0) ai -= (longint'(1) << w);
      if (((bi >> (w - 1)) & 1) != 0) bi -= (longint'(1) << w);
      lo = -(longint'(1) << (w - 1));
      hi = (longint'(1) << (w - 1)) - 1;
    end else begin
      lo = 0;
      hi = m;
    end
    p  = ai * bi;
    sh = p >>> f;
    c  = sh;
    e.sat = 1'b0;
    if (sh > hi) begin c = hi; e.sat = 1'b1; end
    if (sh < lo) begin c = lo; e.sat = 1'b1; end
    e.res = 36'(p & ((longint'(1) << (2 * w)) - 1));
    e.fx  = 18'(c & m);
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, req);
  endtask

  task automatic mon(input int i, input logic [35:0] r, input logic [17:0] fx, input logic s);
    exp_t e;
    chk($sformatf("dut%0d done with pending start", i), 64'(sb[i].size() != 0), 64'd1);
    if (sb[i].size() != 0) begin
      e = sb[i].pop_front();
      chk($sformatf("dut%0d res/fx/sat", i), 64'({r, fx, s}), 64'({e.res, e.fx, e.sat}));
    end
  endtask

  always @(negedge CLK) if (if0.done) mon(0, if0.result, if0.result_fx, if0.sat);
  always @(negedge CLK) if (if1.done) mon(1, if1.result, if1.result_fx, if1.sat);
  always @(negedge CLK) if (if2.done) mon(2, if2.result, if2.result_fx, if2.sat);
  always @(negedge CLK)
    if (if3.done) mon(3, {20'b0, if3.result}, {10'b0, if3.result_fx}, if3.sat);
  always @(negedge CLK)
    if (if4.done) mon(4, {20'b0, if4.result}, {10'b0, if4.result_fx}, if4.sat);

  task automatic push_all(input logic [17:0] ta, input logic [17:0] tb_);
    for (int i = 0; i < 5; i++) sb[i].push_back(model(ta, tb_, cw[i], cs[i], cf[i]));
  endtask

  // One transaction; returns on the negedge where the 18-bit units show done.
  task automatic go(input logic [17:0] ta, input logic [17:0] tb_);
    int cyc, nb;
    a = ta;
    b = tb_;
    start = 1'b1;
    push_all(ta, tb_);
    @(negedge CLK);
    start = 1'b0;
    cyc = 0;
    nb  = 0;
    while (!if0.done && cyc < 40) begin
      if (if0.busy) nb++;
      @(negedge CLK);
      cyc++;
    end
    chk("latency start->done", 64'(cyc), 64'd19);
    chk("busy cycles", 64'(nb), 64'd19);
  endtask

  vec_t tv [10];

  initial begin
    logic [54:0] got;
    int          nsum;

    tv[0] = '{0, 18'd3,       18'd5,       36'd15,           18'd15,      1'b0};
    tv[1] = '{0, 18'd0,       18'h12345,   36'd0,            18'd0,       1'b0};
    tv[2] = '{0, 18'h3FFFF,   18'h3FFFF,   36'hFFFF80001,    18'h3FFFF,   1'b1};
    tv[3] = '{1, 18'h3FFFD,   18'd5,       36'hFFFFFFFF1,    18'h3FFF1,   1'b0};
    tv[4] = '{1, 18'h20000,   18'h20000,   36'h400000000,    18'h1FFFF,   1'b1};
    tv[5] = '{1, 18'h20000,   18'd1,       36'hFFFFE0000,    18'h20000,   1'b0};
    tv[6] = '{1, 18'h20000,   18'h1FFFF,   36'hC00020000,    18'h20000,   1'b1};
    tv[7] = '{2, 18'h08000,   18'h08000,   36'h040000000,    18'h04000,   1'b0};
    tv[8] = '{2, 18'h18000,   18'h18000,   36'h240000000,    18'h1FFFF,   1'b1};
    tv[9] = '{2, 18'h30000,   18'h08000,   36'hF80000000,    18'h38000,   1'b0};

    RST = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    #2 RST = 1'b1;
    #1;
    chk("reset outputs", 64'({if1.busy, if1.done, if1.result, if1.result_fx, if1.sat}), 64'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    for (int i = 0; i < 10; i++) begin
      go(tv[i].a, tv[i].b);
      case (tv[i].sel)
        0:       got = {if0.result, if0.result_fx, if0.sat};
        1:       got = {if1.result, if1.result_fx, if1.sat};
        default: got = {if2.result, if2.result_fx, if2.sat};
      endcase
      chk($sformatf("vector %0d", i), 64'(got), 64'({tv[i].res, tv[i].fx, tv[i].sat}));
    end

    // Async reset mid-calculation: nothing queued, so any later done is spurious.
    a = 18'h00777;
    b = 18'h00333;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (6) @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("async reset dut0", 64'({if0.busy, if0.done, if0.result, if0.result_fx, if0.sat}), 64'd0);
    chk("async reset dut2", 64'({if2.busy, if2.done, if2.result, if2.result_fx, if2.sat}), 64'd0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (25) @(negedge CLK);
    go(18'h00123, 18'h3F456);

    // Start held high: each unit accepts every WIDTH+2 edges with the operands then present.
    start = 1'b1;
    for (int t = 0; t < 60; t++) begin
      a = 18'($urandom);
      b = 18'($urandom);
      for (int i = 0; i < 5; i++)
        if (t % (cw[i] + 2) == 0) sb[i].push_back(model(a, b, cw[i], cs[i], cf[i]));
      @(negedge CLK);
    end
    start = 1'b0;
    repeat (25) @(negedge CLK);

    for (int n = 0; n < 1000; n++) go(18'($urandom), 18'($urandom));

    repeat (5) @(negedge CLK);
    nsum = 0;
    for (int i = 0; i < 5; i++) nsum += sb[i].size();
    chk("all queued results delivered", 64'(nsum), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
